spm_sequencer: RTL and testbench

Controller that sequences the 8-bit serial-parallel multiplier (`spm`) inside the user project. It accepts a parallel operand pair through a valid/ready handshake and holds the multiplicand on the spm parallel input. It shifts the multiplier in serially, LSB first and sign-extended, then deserialises the serial product into a parallel two's-complement result offered on a second valid/ready handshake. It sits between the pad-facing logic of `user_project_example` and the `spm` instance, replacing direct pad drive of `x`, `y` and `p`.

---
 rtl/spm_seq_pkg.sv | 16 +
 rtl/spm_sequencer.sv | 111 +++++++++++
 tb/tb_spm_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spm_seq_pkg.sv
// Shared types and constants for the spm sequencer.
// Sizes match the 8-bit serial-parallel multiplier in the user project.
package spm_seq_pkg;

    localparam int SPM_N           = 8;
    localparam int SPM_LAT_DEFAULT = 1;
    localparam int SPM_RUN_CYCLES  = 2 * SPM_N + SPM_LAT_DEFAULT;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLR,
        S_RUN,
        S_DONE
    } seq_state_e;

endpackage

// File: rtl/spm_sequencer.sv
// Handshake front-end for the serial-parallel multiplier: loads x, shifts y
// in LSB first (sign-extended) and collects the 2N-bit serial product.
module spm_sequencer
    import spm_seq_pkg::*;
#(
    parameter int N       = SPM_N,
    parameter int SPM_LAT = SPM_LAT_DEFAULT
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           in_valid_i,
    output logic           in_ready_o,
    input  logic [N-1:0]   in_a_i,
    input  logic [N-1:0]   in_b_i,
    output logic           out_valid_o,
    input  logic           out_ready_i,
    output logic [2*N-1:0] out_prod_o,
    output logic           spm_rst_o,
    output logic [N-1:0]   spm_x_o,
    output logic           spm_y_o,
    input  logic           spm_p_i,
    output logic           busy_o
);

    localparam int RUN_CYC = 2 * N + SPM_LAT;
    localparam int CW      = $clog2(RUN_CYC + 1);

    localparam logic [CW-1:0] CNT_LAST = CW'(RUN_CYC - 1);
    localparam logic [CW-1:0] CNT_LAT  = CW'(SPM_LAT);

    seq_state_e       state_q;
    seq_state_e       state_d;
    logic [CW-1:0]    cnt_q;
    logic [N-1:0]     x_q;
    logic [N-1:0]     y_sh_q;
    logic [2*N-1:0]   prod_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (in_valid_i) state_d = S_CLR;
            S_CLR:   state_d = S_RUN;
            S_RUN:   if (cnt_q == CNT_LAST) state_d = S_DONE;
            S_DONE:  if (out_ready_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from the current state; spm is held in clear except in RUN
    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        spm_rst_o   = 1'b1;
        spm_y_o     = 1'b0;
        busy_o      = 1'b0;
        unique case (state_q)
            S_IDLE: in_ready_o = 1'b1;
            S_CLR:  busy_o = 1'b1;
            S_RUN: begin
                busy_o    = 1'b1;
                spm_rst_o = 1'b0;
                spm_y_o   = y_sh_q[0];
            end
            S_DONE:  out_valid_o = 1'b1;
            default: in_ready_o = 1'b0;
        endcase
    end

    // Operand capture, serial y shift-out and product shift-in
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= '0;
            x_q    <= '0;
            y_sh_q <= '0;
            prod_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid_i) begin
                        x_q    <= in_a_i;
                        y_sh_q <= in_b_i;
                        prod_q <= '0;
                    end
                end
                S_CLR: cnt_q <= '0;
                S_RUN: begin
                    cnt_q  <= cnt_q + CW'(1);
                    y_sh_q <= {y_sh_q[N-1], y_sh_q[N-1:1]};
                    if (cnt_q >= CNT_LAT) begin
                        prod_q <= {spm_p_i, prod_q[2*N-1:1]};
                    end
                end
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign spm_x_o    = x_q;
    assign out_prod_o = prod_q;

endmodule

// File: tb/tb_spm_sequencer.sv
// Scoreboard bench for spm_sequencer driving a behavioural serial-parallel
// multiplier; products are compared against a signed a*b reference.
module tb_spm_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_prod;
    logic        spm_rst;
    logic [7:0]  spm_x;
    logic        spm_y;
    logic        spm_p = 1'b0;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_done = 0;
    int last_acc = 0;
    int clr_edge = -1;
    logic [7:0]  clr_a = '0;
    logic [15:0] last_prod = '0;
    logic        prev_valid = 1'b0;
    logic        rnd_on = 1'b0;

    logic [15:0] exp_q[$];
    int          acc_q[$];

    spm_sequencer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_a_i      (in_a),
        .in_b_i      (in_b),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_prod_o  (out_prod),
        .spm_rst_o   (spm_rst),
        .spm_x_o     (spm_x),
        .spm_y_o     (spm_y),
        .spm_p_i     (spm_p),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural spm: product bit k leaves one cycle after y bit k arrives
    logic [15:0] sm_acc = '0;
    logic [4:0]  sm_k = '0;
    logic [15:0] sm_next;
    logic [15:0] sm_prod;

    always_comb begin
        sm_next = sm_acc | (16'(spm_y) << sm_k);
        sm_prod = {{8{spm_x[7]}}, spm_x} * sm_next;
    end

    always @(posedge clk) begin
        if (spm_rst) begin
            sm_acc <= '0;
            sm_k   <= '0;
            spm_p  <= 1'b0;
        end else begin
            sm_acc <= sm_next;
            sm_k   <= sm_k + 5'd1;
            spm_p  <= sm_prod[sm_k[3:0]] & ~sm_k[4];
        end
    end

    function automatic logic [15:0] ref_mul(input logic [7:0] a,
                                            input logic [7:0] b);
        int pa = $signed(a);
        int pb = $signed(b);
        return 16'(pa * pb);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        tests++;
        fails++;
        $display("FAIL %s", name);
    endtask

    // Monitor: records accepts, checks CLR cycle, latency and products
    initial begin : monitor
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 1'b0;
                clr_edge   = -1;
            end else begin
                if (cyc == clr_edge) begin
                    check("clr_spm_rst", 32'(spm_rst), 32'd1);
                    check("clr_spm_x", 32'(spm_x), 32'(clr_a));
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(ref_mul(in_a, in_b));
                    acc_q.push_back(cyc + 1);
                    clr_edge = cyc + 1;
                    clr_a    = in_a;
                    last_acc = cyc + 1;
                    n_acc++;
                end
                if (out_valid && !prev_valid) begin
                    if (acc_q.size() == 0) flag("spurious_out_valid");
                    else check("latency", 32'(cyc - acc_q[0]), 32'd18);
                end
                prev_valid = out_valid;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        flag("unexpected_product");
                    end else begin
                        e = exp_q.pop_front();
                        void'(acc_q.pop_front());
                        check("product", 32'(out_prod), 32'(e));
                        last_prod = out_prod;
                        n_done++;
                    end
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b,
                        input int gap);
        int t;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            t++;
            if (t > 500) begin
                flag("send_timeout");
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) flag("drain_timeout");
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_prod"}, 32'(out_prod), 32'd0);
        check({tag, "_spm_x"}, 32'(spm_x), 32'd0);
        check({tag, "_spm_y"}, 32'(spm_y), 32'd0);
        check({tag, "_spm_rst"}, 32'(spm_rst), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        logic [7:0]  da[4];
        logic [7:0]  db[4];
        logic [15:0] dp[4];
        int          edges[4];
        logic [15:0] held;
        int          acc0;
        int          done0;
        int          t;

        da = '{8'h05, 8'hFD, 8'h80, 8'h7F};
        db = '{8'h03, 8'h05, 8'h80, 8'h7F};
        dp = '{16'h000F, 16'hFFF1, 16'h4000, 16'h3F01};

        #3;
        check_reset_vals("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sync();

        // Directed products from the spec
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(da[i], db[i], 0);
            drain();
            check("dir_prod", 32'(last_prod), 32'(dp[i]));
            sync();
        end

        // Back-pressure hold with an ignored input pulse
        out_ready = 1'b0;
        send(8'h12, 8'h34, 0);
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("bp_valid_rise", 32'(out_valid), 32'd1);
        held = out_prod;
        acc0 = n_acc;
        check("bp_prod_value", 32'(held), 32'h03A8);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (i == 10) begin
                in_a     = 8'h44;
                in_b     = 8'h55;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            check("bp_valid_hold", 32'(out_valid), 32'd1);
            check("bp_prod_hold", 32'(out_prod), 32'(held));
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        check("bp_no_accept", 32'(n_acc), 32'(acc0));
        sync();
        out_ready = 1'b1;
        drain();
        check("bp_final", 32'(last_prod), 32'h03A8);
        sync();

        // Back-to-back stream, 20-cycle initiation interval
        for (int i = 0; i < 4; i++) begin
            send(8'(i * 37 + 9), 8'(8'hF0 + i * 5), 0);
            edges[i] = last_acc;
        end
        drain();
        for (int i = 1; i < 4; i++) begin
            check("stream_ii", 32'(edges[i] - edges[i-1]), 32'd20);
        end
        sync();

        // Reset in the middle of RUN (count 7)
        send(8'h11, 8'h22, 0);
        repeat (8) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        acc_q.delete();
        #1;
        check_reset_vals("mid_rst");
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("hold_rst");
        @(negedge clk);
        rst_n = 1'b1;
        sync();
        send(8'h02, 8'h02, 0);
        drain();
        check("rst_prod", 32'(last_prod), 32'h0004);
        sync();

        // Randomised signed pairs with valid/ready gaps
        acc0   = n_acc;
        done0  = n_done;
        rnd_on = 1'b1;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    send(8'($urandom), 8'($urandom), $urandom_range(0, 3));
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 9) < 7);
                end
            end
        join
        out_ready = 1'b1;
        drain();
        check("rnd_accepts", 32'(n_acc - acc0), 32'd1000);
        check("rnd_products", 32'(n_done - done0), 32'd1000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
